// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: four-channel LED PWM controller.
// A free-running period counter drives four PWM comparators. The host queues
// SET / FADE / BREATHE / OFF commands per channel. Each command is held in a
// shadow register and only takes effect at the period boundary, so a channel's
// waveform never changes partway through a period. FADE and BREATHE move the
// duty by one count each time the shared step counter wraps.
// Optional build macro: PWM_GAMMA_EN. When it is defined, the compare value is
// duty*duty/PERIOD, which gives a perceptually linear fade. When it is not
// defined, the compare value is the duty itself.
module pwm_fade_sequencer #(
    parameter int PERIOD       = 100,
    parameter int CW           = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic [1:0]    cfg_mode,
    input  logic [CW-1:0] cfg_target,
    output logic [3:0]    led,
    output logic [3:0]    busy,
    output logic          period_tick
);
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CW-1:0] PERIOD_C    = CW'(PERIOD);
    localparam logic [CW-1:0] LAST_C      = CW'(PERIOD - 1);
    localparam logic [SW-1:0] STEP_LAST_C = SW'(STEP_PERIODS - 1);

    localparam logic [1:0] MODE_SET     = 2'd0;
    localparam logic [1:0] MODE_FADE    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_FADE, ST_BR_UP, ST_BR_DN} state_t;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [SW-1:0] step_reg;
    logic          cfg_ready_reg;
    logic          boundary;
    logic          step_now;
    logic          accept;
    logic [CW-1:0] target_clamped;

    assign boundary       = (cnt_reg == LAST_C);
    assign step_now       = boundary && (step_reg == STEP_LAST_C);
    assign cnt_next       = boundary ? '0 : cnt_reg + CW'(1);
    assign accept         = cfg_valid && cfg_ready_reg;
    assign target_clamped = (cfg_target > PERIOD_C) ? PERIOD_C : cfg_target;
    assign cfg_ready      = cfg_ready_reg;
    assign period_tick    = boundary;

    // Period counter, shared fade-step counter, and command-port ready.
    // Ready is computed from the next count, so it is already low on the boundary cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            step_reg      <= '0;
            cfg_ready_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            cfg_ready_reg <= (cnt_next != LAST_C);
            if (boundary) begin
                step_reg <= (step_reg == STEP_LAST_C) ? '0 : step_reg + SW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [CW-1:0] duty_reg;
            logic [CW-1:0] duty_next;
            logic [CW-1:0] duty_inc;
            logic [CW-1:0] duty_dec;
            logic [CW-1:0] cmp_reg;
            logic [CW-1:0] cmp_next;
            logic [CW-1:0] tgt_reg;
            logic [CW-1:0] tgt_next;
            logic [CW-1:0] shadow_reg;
            logic [1:0]    pmode_reg;
            logic          pend_reg;
            logic          led_reg;
            state_t        state_reg;
            state_t        state_next;

            assign duty_inc = duty_reg + CW'(1);
            assign duty_dec = duty_reg - CW'(1);

`ifdef PWM_GAMMA_EN
            logic [2*CW-1:0] duty_sq;
            assign duty_sq  = {{CW{1'b0}}, duty_next} * {{CW{1'b0}}, duty_next};
            assign cmp_next = CW'(duty_sq / (2*CW)'(PERIOD));
`else
            assign cmp_next = duty_next;
`endif

            // Boundary behaviour: apply a pending command, or else take one fade/breathe step.
            always_comb begin
                duty_next  = duty_reg;
                tgt_next   = tgt_reg;
                state_next = state_reg;
                if (boundary) begin
                    if (pend_reg) begin
                        tgt_next = shadow_reg;
                        case (pmode_reg)
                            MODE_SET: begin
                                duty_next  = shadow_reg;
                                state_next = ST_IDLE;
                            end
                            MODE_FADE: begin
                                state_next = (shadow_reg == duty_reg) ? ST_IDLE : ST_FADE;
                            end
                            MODE_BREATHE: begin
                                state_next = ST_BR_UP;
                            end
                            default: begin
                                duty_next  = '0;
                                state_next = ST_IDLE;
                            end
                        endcase
                    end else if (step_now) begin
                        case (state_reg)
                            ST_FADE: begin
                                if (duty_reg < tgt_reg) begin
                                    duty_next  = duty_inc;
                                    state_next = (duty_inc == tgt_reg) ? ST_IDLE : ST_FADE;
                                end else if (duty_reg > tgt_reg) begin
                                    duty_next  = duty_dec;
                                    state_next = (duty_dec == tgt_reg) ? ST_IDLE : ST_FADE;
                                end else begin
                                    state_next = ST_IDLE;
                                end
                            end
                            ST_BR_UP: begin
                                if (duty_reg < tgt_reg) begin
                                    duty_next  = duty_inc;
                                    state_next = (duty_inc == tgt_reg) ? ST_BR_DN : ST_BR_UP;
                                end else if (duty_reg != '0) begin
                                    // Started above the target: head down first.
                                    duty_next  = duty_dec;
                                    state_next = (duty_dec == '0) ? ST_BR_UP : ST_BR_DN;
                                end
                            end
                            ST_BR_DN: begin
                                if (duty_reg != '0) begin
                                    duty_next  = duty_dec;
                                    state_next = (duty_dec == '0) ? ST_BR_UP : ST_BR_DN;
                                end else if (tgt_reg != '0) begin
                                    duty_next  = CW'(1);
                                    state_next = (tgt_reg == CW'(1)) ? ST_BR_DN : ST_BR_UP;
                                end else begin
                                    state_next = ST_BR_UP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // Channel registers: shadow capture on accept, commit and PWM compare.
            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_reg   <= '0;
                    cmp_reg    <= '0;
                    tgt_reg    <= '0;
                    shadow_reg <= '0;
                    pmode_reg  <= MODE_SET;
                    pend_reg   <= 1'b0;
                    led_reg    <= 1'b0;
                    state_reg  <= ST_IDLE;
                end else begin
                    led_reg <= (cnt_reg < cmp_reg);
                    if (accept && (cfg_ch == 2'(gi))) begin
                        pend_reg   <= 1'b1;
                        shadow_reg <= target_clamped;
                        pmode_reg  <= cfg_mode;
                    end else if (boundary) begin
                        pend_reg <= 1'b0;
                    end
                    if (boundary) begin
                        duty_reg  <= duty_next;
                        cmp_reg   <= cmp_next;
                        tgt_reg   <= tgt_next;
                        state_reg <= state_next;
                    end
                end
            end

            assign led[gi]  = led_reg;
            assign busy[gi] = (state_reg != ST_IDLE);
        end
    endgenerate
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Testbench for pwm_fade_sequencer. A cycle-level reference model tracks the
// period count, per-channel duty, pending commands, and fade and breathe
// progress with plain integers. Each scenario task compares the DUT outputs
// against the model, against high-cycle counts derived from the behaviour
// rules, or against both.
module tb_pwm_fade_sequencer;
    localparam int P  = 100;
    localparam int CW = 8;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [CW-1:0] cfg_target = '0;
    logic [3:0]    led;
    logic [3:0]    busy;
    logic          period_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int win_hi[4];

    pwm_fade_sequencer #(.PERIOD(P), .CW(CW), .STEP_PERIODS(S)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_target(cfg_target),
        .led(led), .busy(busy), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_cnt, m_step;
    bit         m_ready;
    logic [3:0] m_led;
    int         m_duty[4], m_tgt[4], m_kind[4], m_dir[4], m_pmode[4], m_ptgt[4];
    bit         m_pend[4];

    function automatic int cmp_of(int d);
`ifdef PWM_GAMMA_EN
        return (d * d) / P;
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (m_kind[i] != 0);
        return b;
    endfunction

    task automatic apply_cmd(input int i);
        m_tgt[i] = m_ptgt[i];
        case (m_pmode[i])
            0: begin m_duty[i] = m_tgt[i]; m_kind[i] = 0; end
            1: m_kind[i] = (m_tgt[i] == m_duty[i]) ? 0 : 1;
            2: begin m_kind[i] = 2; m_dir[i] = 1; end
            default: begin m_duty[i] = 0; m_kind[i] = 0; end
        endcase
    endtask

    task automatic advance(input int i);
        if (m_kind[i] == 1) begin
            if (m_duty[i] < m_tgt[i]) m_duty[i]++;
            else if (m_duty[i] > m_tgt[i]) m_duty[i]--;
            if (m_duty[i] == m_tgt[i]) m_kind[i] = 0;
        end else if (m_kind[i] == 2) begin
            if (m_dir[i] > 0 && m_duty[i] < m_tgt[i]) begin
                m_duty[i]++;
                if (m_duty[i] == m_tgt[i]) m_dir[i] = -1;
            end else begin
                m_dir[i] = -1;
                if (m_duty[i] > 0) begin
                    m_duty[i]--;
                    if (m_duty[i] == 0) m_dir[i] = 1;
                end else begin
                    m_dir[i] = 1;
                    if (m_tgt[i] > 0) begin
                        m_duty[i] = 1;
                        if (m_duty[i] == m_tgt[i]) m_dir[i] = -1;
                    end
                end
            end
        end
    endtask

    task automatic model_update();
        bit stepnow;
        if (rst) begin
            m_cnt = 0; m_step = 0; m_ready = 0; m_led = '0;
            for (int i = 0; i < 4; i++) begin
                m_duty[i] = 0; m_tgt[i] = 0; m_kind[i] = 0; m_dir[i] = 1;
                m_pend[i] = 0; m_pmode[i] = 0; m_ptgt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) m_led[i] = (m_cnt < cmp_of(m_duty[i]));
            if (cfg_valid && m_ready) begin
                m_pend[cfg_ch]  = 1;
                m_pmode[cfg_ch] = int'(cfg_mode);
                m_ptgt[cfg_ch]  = (int'(cfg_target) > P) ? P : int'(cfg_target);
            end
            if (m_cnt == P - 1) begin
                stepnow = (m_step == S - 1);
                m_step  = (m_step + 1) % S;
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i]) begin
                        m_pend[i] = 0;
                        apply_cmd(i);
                    end else if (stepnow) begin
                        advance(i);
                    end
                end
            end
            m_cnt   = (m_cnt + 1) % P;
            m_ready = (m_cnt != P - 1);
        end
    endtask

    always @(posedge clk) model_update();

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input int ch, input int mode, input int tgt);
        cfg_ch = ch[1:0]; cfg_mode = mode[1:0]; cfg_target = tgt[CW-1:0]; cfg_valid = 1'b1;
        for (int t = 0; t < 2 * P; t++) begin
            if (cfg_ready === 1'b1) begin
                @(negedge clk);
                cfg_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL send_cmd: cfg_ready stayed low for %0d cycles (ch %0d)", 2 * P, ch);
    endtask

    task automatic wait_tick();
        for (int t = 0; t < 2 * P; t++) begin
            @(negedge clk);
            if (period_tick === 1'b1) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_tick: period_tick not seen within %0d cycles", 2 * P);
    endtask

    // Counts high cycles per channel over the whole period that follows the next boundary.
    task automatic measure_window();
        wait_tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) win_hi[i] = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (led[i] === 1'b1) win_hi[i]++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int ticks, first_tick, second_tick;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (led !== 4'b0)      begin n_fail++; $display("FAIL reset_led: got %b expected 0000", led); end
        n_checks++; if (busy !== 4'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
        n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
        rst = 1'b0;
        ticks = 0; first_tick = -1; second_tick = -1;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            n_checks++;
            if (period_tick !== (m_cnt == P - 1)) begin
                n_fail++; $display("FAIL tick_model: cycle %0d got %b expected %b", k, period_tick, (m_cnt == P - 1));
            end
            n_checks++;
            if (cfg_ready !== m_ready) begin
                n_fail++; $display("FAIL ready_model: cycle %0d got %b expected %b", k, cfg_ready, m_ready);
            end
            if (period_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = k; else if (second_tick < 0) second_tick = k;
                n_checks++;
                if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ready_on_boundary: got %b expected 0", cfg_ready); end
            end
        end
        n_checks++; if (ticks != 2) begin n_fail++; $display("FAIL tick_count: got %0d expected 2", ticks); end
        n_checks++; if (second_tick - first_tick != P) begin n_fail++; $display("FAIL tick_spacing: got %0d expected %0d", second_tick - first_tick, P); end
        $display("test_reset: %0d ticks, first at cycle %0d", ticks, first_tick);
    endtask

    task automatic test_set();
        int exp_hi[4];
        exp_hi = '{25, 50, 75, 100};
        for (int i = 0; i < 4; i++) send_cmd(i, 0, exp_hi[i]);
        measure_window();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (win_hi[i] != exp_hi[i]) begin n_fail++; $display("FAIL set_duty ch%0d: got %0d high cycles expected %0d", i, win_hi[i], exp_hi[i]); end
            $display("test_set: ch%0d high %0d/%0d", i, win_hi[i], P);
        end
    endtask

    task automatic test_mid_update();
        int hi_old, hi_new;
        wait_tick();
        @(negedge clk);
        hi_old = 0; hi_new = 0;
        for (int k = 1; k <= 2 * P; k++) begin
            if (k == 30) begin cfg_ch = 2'd2; cfg_mode = 2'd0; cfg_target = 8'd40; cfg_valid = 1'b1; end
            if (k == 31) cfg_valid = 1'b0;
            @(negedge clk);
            if (led[2] === 1'b1) begin if (k <= P) hi_old++; else hi_new++; end
            n_checks++;
            if (led[2] !== m_led[2]) begin n_fail++; $display("FAIL mid_update_led2: cycle %0d got %b expected %b", k, led[2], m_led[2]); end
        end
        n_checks++; if (hi_old != 75) begin n_fail++; $display("FAIL mid_update_old: got %0d expected 75", hi_old); end
        n_checks++; if (hi_new != 40) begin n_fail++; $display("FAIL mid_update_new: got %0d expected 40", hi_new); end
        $display("test_mid_update: period with write %0d high, next period %0d high", hi_old, hi_new);
    endtask

    task automatic test_back_to_back();
        send_cmd(1, 0, 30);
        send_cmd(1, 0, 60);
        measure_window();
        n_checks++; if (win_hi[1] != 60) begin n_fail++; $display("FAIL back_to_back: got %0d expected 60", win_hi[1]); end
        $display("test_back_to_back: ch1 high %0d", win_hi[1]);
    endtask

    task automatic test_clamp();
        int exp2;
`ifdef PWM_GAMMA_EN
        exp2 = 25;
`else
        exp2 = 50;
`endif
        send_cmd(3, 0, 200);
        send_cmd(2, 0, 50);
        measure_window();
        n_checks++; if (win_hi[3] != P) begin n_fail++; $display("FAIL clamp: got %0d expected %0d", win_hi[3], P); end
        n_checks++; if (win_hi[2] != exp2) begin n_fail++; $display("FAIL compare_map: got %0d expected %0d", win_hi[2], exp2); end
        $display("test_clamp: ch3 high %0d, ch2 duty 50 high %0d", win_hi[3], win_hi[2]);
    endtask

    task automatic test_fade();
        int rise, fall;
        send_cmd(1, 0, 0);
        wait_tick();
        send_cmd(1, 1, 10);
        rise = -1; fall = -1;
        for (int k = 0; k < 5000 && fall < 0; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== m_busy()) begin n_fail++; $display("FAIL fade_busy: cycle %0d got %b expected %b", k, busy, m_busy()); end
            n_checks++;
            if (led !== m_led) begin n_fail++; $display("FAIL fade_led: cycle %0d got %b expected %b", k, led, m_led); end
            if (rise < 0 && busy[1] === 1'b1) rise = k;
            if (rise >= 0 && busy[1] === 1'b0) fall = k;
        end
        n_checks++;
        if (rise < 0 || fall < 0) begin
            n_fail++; $display("FAIL fade_busy_window: rise %0d fall %0d expected both seen", rise, fall);
        end else if (fall - rise < 37 * P || fall - rise > 40 * P) begin
            n_fail++; $display("FAIL fade_duration: got %0d cycles expected %0d..%0d", fall - rise, 37 * P, 40 * P);
        end
        measure_window();
        n_checks++; if (win_hi[1] != 10) begin n_fail++; $display("FAIL fade_final: got %0d expected 10", win_hi[1]); end
        $display("test_fade: busy for %0d cycles, final high %0d", fall - rise, win_hi[1]);
    endtask

    task automatic test_breathe_off();
        int seq[$];
        int exp_seq[8];
        int hi;
        exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
        send_cmd(0, 0, 0);
        wait_tick();
        send_cmd(0, 2, 3);
        wait_tick();
        @(negedge clk);
        for (int p = 0; p < 32; p++) begin
            hi = 0;
            for (int k = 0; k < P; k++) begin
                @(negedge clk);
                if (led[0] === 1'b1) hi++;
                n_checks++;
                if (led !== m_led || busy !== m_busy()) begin
                    n_fail++; $display("FAIL breathe_model: period %0d got led %b busy %b expected led %b busy %b", p, led, busy, m_led, m_busy());
                end
            end
            if (seq.size() == 0 || seq[$] != hi) seq.push_back(hi);
        end
        n_checks++;
        if (seq.size() < 8) begin
            n_fail++; $display("FAIL breathe_seq_len: got %0d distinct steps expected at least 8", seq.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_checks++;
                if (seq[j] != exp_seq[j]) begin n_fail++; $display("FAIL breathe_seq[%0d]: got %0d expected %0d", j, seq[j], exp_seq[j]); end
            end
        end
        send_cmd(0, 3, 0);
        wait_tick();
        @(negedge clk);
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL off_busy: got %b expected 0", busy[0]); end
        measure_window();
        n_checks++; if (win_hi[0] != 0) begin n_fail++; $display("FAIL off_duty: got %0d expected 0", win_hi[0]); end
        $display("test_breathe_off: %0d distinct duty steps, after OFF high %0d", seq.size(), win_hi[0]);
    endtask

    task automatic test_reset_mid();
        send_cmd(1, 1, 90);
        wait_tick();
        repeat (9 * P) @(negedge clk);
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL mid_fade_busy: got %b expected 1", busy[1]); end
        send_cmd(2, 0, 77);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (led !== 4'b0 || busy !== 4'b0 || cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got led %b busy %b ready %b expected all 0", led, busy, cfg_ready);
        end
        rst = 1'b0;
        measure_window();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (win_hi[i] != 0) begin n_fail++; $display("FAIL reset_mid_duty ch%0d: got %0d expected 0", i, win_hi[i]); end
        end
        $display("test_reset_mid: all channels dark after reset");
    endtask

    task automatic test_random();
        int accepted;
        accepted = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            n_checks++;
            if (led !== m_led) begin n_fail++; $display("FAIL rand_led: cycle %0d got %b expected %b", k, led, m_led); end
            n_checks++;
            if (busy !== m_busy()) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b expected %b", k, busy, m_busy()); end
            n_checks++;
            if (period_tick !== (m_cnt == P - 1)) begin n_fail++; $display("FAIL rand_tick: cycle %0d got %b", k, period_tick); end
            n_checks++;
            if (cfg_ready !== m_ready) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b expected %b", k, cfg_ready, m_ready); end
            if (cfg_valid && cfg_ready) accepted++;
            cfg_valid  = ($urandom_range(0, 29) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_target = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 6)) : CW'($urandom_range(0, 255));
        end
        cfg_valid = 1'b0;
        $display("test_random: %0d commands accepted", accepted);
    endtask

    initial begin
        test_reset();
        test_set();
        test_mid_update();
        test_back_to_back();
        test_clamp();
        test_fade();
        test_breathe_off();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
